// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the requester handshakes (IF, MEM) and the byte-wide
// RAM port of mem_ctrl.
//   slave  : the controller's view (requests in, busy/ready/data and RAM strobes out)
//   master : the requesters' and RAM's view (the reverse)
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // instruction fetch requester
  logic                  if_read;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_busy;
  logic                  if_ready;
  logic [31:0]           if_data;
  // data memory requester
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_width;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_busy;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  // byte-wide RAM
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  if_read, if_addr,
    output if_busy, if_ready, if_data,
    input  mem_read, mem_write, mem_width, mem_addr, mem_wdata,
    output mem_busy, mem_ready, mem_rdata,
    output ram_addr, ram_wr, ram_dout,
    input  ram_din
  );

  modport master (
    output if_read, if_addr,
    input  if_busy, if_ready, if_data,
    output mem_read, mem_write, mem_width, mem_addr, mem_wdata,
    input  mem_busy, mem_ready, mem_rdata,
    input  ram_addr, ram_wr, ram_dout,
    output ram_din
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the IF and MEM requesters onto a byte-wide RAM and
// serialises each 1/2/4-byte transfer little-endian, one transaction at a time.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_ctrl_if.slave (IF handshake, MEM handshake, RAM port)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting; MEM write > MEM read > IF read accepted at next edge
// READ    | issuing byte addresses and collecting ram_din into r_asm
// WRITE   | issuing byte addresses with ram_wr held high
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  mem_ctrl_if.slave bus
);
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_owner_if;
  logic [2:0]      r_cnt;
  logic [2:0]      r_nbytes;
  logic [AW-1:0]   r_base;
  logic [31:0]     r_wdata;
  logic [31:0]     r_asm;
  logic [AW-1:0]   r_ram_addr;
  logic            r_ram_wr;
  logic [7:0]      r_ram_dout;
  logic [31:0]     r_if_data;
  logic            r_if_ready;
  logic [31:0]     r_mem_rdata;
  logic            r_mem_ready;

  // w_step is the index of the edge currently being taken (E1, E2, ...).
  logic [2:0]      w_step;
  logic [2:0]      w_cap_idx;
  logic [2:0]      w_mem_nbytes;
  logic [AW-1:0]   w_next_addr;
  logic [7:0]      w_wbyte;
  logic [31:0]     w_asm_next;

  assign w_step      = r_cnt + 3'd1;
  // RAM data lags its address by two edges, so edge j+2 captures byte j.
  assign w_cap_idx   = w_step - 3'd2;
  assign w_next_addr = r_base + AW'(w_step);
  assign w_wbyte     = r_wdata[{w_step[1:0], 3'b000} +: 8];
  assign w_asm_next  = r_asm | ({24'd0, bus.ram_din} << {w_cap_idx[1:0], 3'b000});

  always_comb begin
    w_mem_nbytes = 3'd4;
    case (bus.mem_width)
      2'b00:   w_mem_nbytes = 3'd1;
      2'b01:   w_mem_nbytes = 3'd2;
      default: w_mem_nbytes = 3'd4;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner_if  <= 1'b0;
      r_cnt       <= 3'd0;
      r_nbytes    <= 3'd0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_asm       <= 32'd0;
      r_ram_addr  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'd0;
      r_if_data   <= 32'd0;
      r_if_ready  <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_mem_ready <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_write) begin
            r_state    <= ST_WRITE;
            r_owner_if <= 1'b0;
            r_nbytes   <= w_mem_nbytes;
            r_base     <= bus.mem_addr;
            r_wdata    <= bus.mem_wdata;
            r_cnt      <= 3'd0;
            r_ram_addr <= bus.mem_addr;
            r_ram_wr   <= 1'b1;
            r_ram_dout <= bus.mem_wdata[7:0];
          end else if (bus.mem_read) begin
            r_state    <= ST_READ;
            r_owner_if <= 1'b0;
            r_nbytes   <= w_mem_nbytes;
            r_base     <= bus.mem_addr;
            r_cnt      <= 3'd0;
            r_asm      <= 32'd0;
            r_ram_addr <= bus.mem_addr;
          end else if (bus.if_read) begin
            r_state    <= ST_READ;
            r_owner_if <= 1'b1;
            r_nbytes   <= 3'd4;
            r_base     <= bus.if_addr;
            r_cnt      <= 3'd0;
            r_asm      <= 32'd0;
            r_ram_addr <= bus.if_addr;
          end
        end
        ST_READ: begin
          r_cnt <= w_step;
          if (w_step < r_nbytes) r_ram_addr <= w_next_addr;
          if (w_step >= 3'd2)    r_asm      <= w_asm_next;
          if (w_step == r_nbytes + 3'd1) begin
            r_state <= ST_IDLE;
            if (r_owner_if) begin
              r_if_data  <= w_asm_next;
              r_if_ready <= 1'b1;
            end else begin
              r_mem_rdata <= w_asm_next;
              r_mem_ready <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_cnt <= w_step;
          if (w_step < r_nbytes) begin
            r_ram_addr <= w_next_addr;
            r_ram_dout <= w_wbyte;
          end else begin
            r_ram_wr    <= 1'b0;
            r_mem_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_busy  = (r_state != ST_IDLE);
  assign bus.if_busy   = (r_state != ST_IDLE) | bus.mem_read | bus.mem_write;
  assign bus.if_ready  = r_if_ready;
  assign bus.if_data   = r_if_data;
  assign bus.mem_ready = r_mem_ready;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_dout  = r_ram_dout;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized traffic; expectations come
// from a byte-array reference memory and are scoreboarded per requester.
module tb_mem_ctrl;
  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();
  mem_ctrl #(.ADDR_WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t mem_q[$];
  exp_t if_q[$];

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int          wr_cnt;
  logic [31:0] last_wr_addr;
  logic [7:0]  last_wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address sampled at the edge, data visible after it.
  always @(posedge clk) begin
    bus.ram_din <= ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : 8'h00;
    if (bus.ram_wr) begin
      ram[bus.ram_addr] = bus.ram_dout;
      wr_cnt++;
      last_wr_addr = bus.ram_addr;
      last_wr_data = bus.ram_dout;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < n; j++) r = r | (32'(ref_rd(a + 32'(j))) << (8 * j));
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Monitor: pops the owner's queue on every ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_ready) begin
      if (mem_q.size() == 0) chk("mem_unexpected_ready", 1, 0);
      else begin
        e = mem_q.pop_front();
        chk("mem_ready_cycle", 64'(cyc), 64'(e.exp_cyc));
        if (e.is_read) chk("mem_rdata", bus.mem_rdata, e.data);
      end
    end
    if (bus.if_ready) begin
      if (if_q.size() == 0) chk("if_unexpected_ready", 1, 0);
      else begin
        e = if_q.pop_front();
        chk("if_ready_cycle", 64'(cyc), 64'(e.exp_cyc));
        chk("if_data", bus.if_data, e.data);
      end
    end
  end

  // Drives one request at the current negedge; `extra` = edges it must wait
  // behind a higher-priority transaction before acceptance.
  task automatic launch(input bit is_if, input bit wr, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d, input int extra);
    exp_t e;
    int   n;
    n = is_if ? 4 : (w == 2'b00 ? 1 : (w == 2'b01 ? 2 : 4));
    e.is_read = !wr;
    e.exp_cyc = cyc + 1 + extra + (wr ? n : n + 1);
    e.data    = 32'd0;
    if (wr) begin
      for (int j = 0; j < n; j++) ref_mem[a + 32'(j)] = d[8*j +: 8];
    end else begin
      e.data = ref_word(a, n);
    end
    if (is_if) begin
      bus.if_read = 1'b1;
      bus.if_addr = a;
      if_q.push_back(e);
    end else begin
      bus.mem_read  = !wr;
      bus.mem_write = wr;
      bus.mem_width = w;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      mem_q.push_back(e);
    end
  endtask

  task automatic drop(input bit is_if);
    if (is_if) bus.if_read = 1'b0;
    else begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask

  task automatic wait_ready(input bit is_if);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_if ? bus.if_ready : bus.mem_ready) seen = 1'b1;
    end
    if (!seen) chk(is_if ? "if_ready_timeout" : "mem_ready_timeout", 0, 1);
    drop(is_if);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    bit          is_if;
    bit          wr;
    int          wr0;

    n_cmp = 0; n_bad = 0; wr_cnt = 0; cyc = 0;
    reset_n = 1'b0;
    bus.if_read = 1'b0; bus.if_addr = 32'd0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_width = 2'b00;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    preload(32'h0, 8'h13); preload(32'h1, 8'h00);
    preload(32'h2, 8'h00); preload(32'h3, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wr", bus.ram_wr, 0);
    chk("rst_mem_busy", bus.mem_busy, 0);
    chk("rst_if_busy", bus.if_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic fetch
    launch(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 0);
    wait_ready(1'b1);
    chk("t1_if_data", bus.if_data, 32'h0000_0013);
    @(negedge clk);
    chk("t1_ready_one_cycle", bus.if_ready, 0);

    // 2: MEM beats IF; IF waits behind it
    launch(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0);
    launch(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 6);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        chk("t2_if_busy", bus.if_busy, 1);
        if (bus.mem_ready) seen = 1'b1;
        else chk("t2_mem_busy", bus.mem_busy, 1);
      end
      if (!seen) chk("t2_mem_timeout", 0, 1);
      drop(1'b0);
    end
    wait_ready(1'b1);

    // 3: single-byte write, then word read over it
    wr0 = wr_cnt;
    launch(1'b0, 1'b1, 2'b00, 32'h2003, 32'hAABB_CCDD, 0);
    wait_ready(1'b0);
    chk("t3_wr_cycles", 64'(wr_cnt - wr0), 1);
    chk("t3_wr_addr", last_wr_addr, 32'h2003);
    chk("t3_wr_data", last_wr_data, 8'hDD);
    launch(1'b0, 1'b0, 2'b10, 32'h2000, 32'h0, 0);
    wait_ready(1'b0);
    chk("t3_rdata", bus.mem_rdata, 32'hDD00_0000);

    // 4: unaligned half read and address wrap
    preload(32'h1001, 8'h34); preload(32'h1002, 8'h12);
    launch(1'b0, 1'b0, 2'b01, 32'h1001, 32'h0, 0);
    wait_ready(1'b0);
    chk("t4_half", bus.mem_rdata, 32'h0000_1234);
    preload(32'hFFFF_FFFF, 8'h5A);
    launch(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0, 0);
    wait_ready(1'b0);
    chk("t4_wrap", bus.mem_rdata, 32'h0000_135A);

    // 5: reset in the middle of a read
    launch(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    drop(1'b0);
    void'(mem_q.pop_back());
    #1;
    chk("t5_mem_rdata", bus.mem_rdata, 0);
    chk("t5_if_data", bus.if_data, 0);
    chk("t5_ram_addr", bus.ram_addr, 0);
    chk("t5_mem_busy", bus.mem_busy, 0);
    chk("t5_mem_ready", bus.mem_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 0);
    wait_ready(1'b0);

    // 6: back-to-back fetches, if_read held across the ready cycle
    launch(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, 0);
    wait_ready(1'b1);
    launch(1'b1, 1'b0, 2'b10, 32'h2000, 32'h0, 0);
    wait_ready(1'b1);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      is_if = ($urandom_range(0, 2) == 0);
      wr    = !is_if && ($urandom_range(0, 1) == 1);
      w     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h3000 + 32'($urandom_range(0, 63));
      launch(is_if, wr, w, a, $urandom, 0);
      wait_ready(is_if);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("mem_q_empty", 64'(mem_q.size()), 0);
    chk("if_q_empty", 64'(if_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
